// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory access controller.
//   imem_state_e : port ownership phase (zero-fill, fetch, program load)
//   IMEM_NOP     : instruction returned for a rejected fetch address
//   IMEM_CLR     : fill word written during the post-reset clear
package imem_pkg;

   localparam int IMEM_XLEN  = 32;
   localparam int IMEM_DEPTH = 64;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      LOAD  = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_NOP = 32'h0000_0013;  // ADDI x0,x0,0
   localparam logic [31:0] IMEM_CLR = 32'h0000_0000;

endpackage

// File: rtl/imem_access_controller_if.sv
// Bus bundle between fetch stage, program loader, instruction memory and
// the access controller.
//   slave  : controller side (consumes requests, drives responses and memory port)
//   master : environment side (fetch/loader/memory model)
interface imem_access_controller_if #(
   parameter int XLEN = 32,
   parameter int AW   = 6
);

   // fetch path
   logic            fetch_req;
   logic [XLEN-1:0] fetch_addr;
   logic            fetch_valid;
   logic [XLEN-1:0] fetch_instr;
   logic            fetch_err;
   logic            fetch_stall;

   // loader path
   logic            ld_start;
   logic            ld_valid;
   logic [XLEN-1:0] ld_addr;
   logic [XLEN-1:0] ld_data;
   logic            ld_ready;
   logic            ld_done;
   logic            ld_err;

   logic            busy;

   // memory port
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr,
      output fetch_valid, fetch_instr, fetch_err, fetch_stall,
      input  ld_start, ld_valid, ld_addr, ld_data, ld_done,
      output ld_ready, ld_err,
      output busy,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output fetch_req, fetch_addr,
      input  fetch_valid, fetch_instr, fetch_err, fetch_stall,
      output ld_start, ld_valid, ld_addr, ld_data, ld_done,
      input  ld_ready, ld_err,
      input  busy,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/imem_addr_check.sv
// Combinational byte-address decode for the instruction memory.
//   addr  : byte address
//   ok    : word aligned and inside the memory
//   index : word index into the memory
module imem_addr_check #(
   parameter int XLEN = 32,
   parameter int AW   = 6
) (
   input  logic [XLEN-1:0] addr,
   output logic            ok,
   output logic [AW-1:0]   index
);

   assign ok    = (addr[1:0] == 2'b00) && (addr[XLEN-1:AW+2] == '0);
   assign index = addr[AW+1:2];

endmodule

// File: rtl/imem_access_controller.sv
// Owner of the single instruction-memory port.
// After reset the whole memory is zero-filled (busy=1), then the port serves
// PC-driven fetches; a loader session (ld_start .. ld_done) takes the port for
// handshaked writes and stalls fetch.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active low
//   bus   : fetch / loader / memory signals (imem_access_controller_if.slave)
module imem_access_controller
   import imem_pkg::*;
#(
   parameter int XLEN  = IMEM_XLEN,
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   imem_access_controller_if.slave       bus
);

   imem_state_e     state_q, state_d;
   logic [AW-1:0]   clr_cnt_q;
   // Low for the first cycle after a reset edge so the memory port shows its
   // idle values even if reset is only held for a single cycle.
   logic            armed_q;

   logic            f_ok, l_ok;
   logic [AW-1:0]   f_idx, l_idx;
   logic            f_acc;

   logic            resp_vld_q;
   logic            ferr_q;
   logic            rd_pend_q;   // response this cycle comes from mem_rdata
   logic [XLEN-1:0] instr_q;     // last presented instruction, held between responses
   logic [XLEN-1:0] instr_w;
   logic            ld_err_q;

   imem_addr_check #(.XLEN(XLEN), .AW(AW)) u_fetch_chk (
      .addr  (bus.fetch_addr),
      .ok    (f_ok),
      .index (f_idx)
   );

   imem_addr_check #(.XLEN(XLEN), .AW(AW)) u_load_chk (
      .addr  (bus.ld_addr),
      .ok    (l_ok),
      .index (l_idx)
   );

   // next state + memory port / status outputs
   always_comb begin
      state_d         = state_q;
      f_acc           = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.fetch_stall = 1'b1;
      bus.ld_ready    = 1'b0;
      bus.busy        = 1'b0;
      case (state_q)
         CLEAR: begin
            bus.busy = 1'b1;
            if (armed_q) begin
               bus.mem_we    = 1'b1;
               bus.mem_addr  = clr_cnt_q;
               bus.mem_wdata = XLEN'(IMEM_CLR);
               if (clr_cnt_q == AW'(DEPTH - 1))
                  state_d = RUN;
            end
         end
         RUN: begin
            bus.fetch_stall = 1'b0;
            f_acc           = bus.fetch_req;
            if (f_acc && f_ok)
               bus.mem_addr = f_idx;
            // a fetch accepted in the same cycle still gets its response
            if (bus.ld_start)
               state_d = LOAD;
         end
         LOAD: begin
            bus.ld_ready = 1'b1;
            if (bus.ld_valid && l_ok) begin
               bus.mem_we    = 1'b1;
               bus.mem_addr  = l_idx;
               bus.mem_wdata = bus.ld_data;
            end
            if (bus.ld_done)
               state_d = RUN;
         end
         default: state_d = CLEAR;
      endcase
   end

   // rdata arrives the cycle after the address, so a good fetch response is
   // taken straight from the memory; otherwise the held value is shown
   assign instr_w         = rd_pend_q ? bus.mem_rdata : instr_q;
   assign bus.fetch_instr = instr_w;
   assign bus.fetch_valid = resp_vld_q;
   assign bus.fetch_err   = ferr_q;
   assign bus.ld_err      = ld_err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= CLEAR;
         clr_cnt_q  <= '0;
         armed_q    <= 1'b0;
         resp_vld_q <= 1'b0;
         ferr_q     <= 1'b0;
         rd_pend_q  <= 1'b0;
         instr_q    <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         armed_q    <= 1'b1;
         if (state_q == CLEAR && armed_q)
            clr_cnt_q <= clr_cnt_q + 1'b1;
         resp_vld_q <= f_acc;
         ferr_q     <= f_acc && !f_ok;
         rd_pend_q  <= f_acc && f_ok;
         instr_q    <= (f_acc && !f_ok) ? XLEN'(IMEM_NOP) : instr_w;
         if (state_q == RUN && bus.ld_start)
            ld_err_q <= 1'b0;
         else if (state_q == LOAD && bus.ld_valid && !l_ok)
            ld_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_access_controller.sv
// Randomized bench for imem_access_controller with a behavioural reference:
// port owner mode, expected memory image and expected fetch response.
module tb_imem_access_controller;

   localparam int M_CLR  = 0;
   localparam int M_RUN  = 1;
   localparam int M_LOAD = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   imem_access_controller_if ifc ();

   imem_access_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   // instruction memory array, 1-cycle synchronous read
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (ifc.mem_we) mem[ifc.mem_addr] <= ifc.mem_wdata;
      ifc.mem_rdata <= mem[ifc.mem_addr];
   end

   int n_chk = 0;
   int n_pass = 0;

   // reference model
   int          mode;
   bit          e_v, e_ferr, e_lerr;
   logic [31:0] e_instr;
   logic [31:0] refm [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
         1:       return $urandom_range(64, 1023) * 4;
         2:       return $urandom;
         default: return $urandom_range(0, 63) * 4;
      endcase
   endfunction

   task automatic model_reset();
      mode    = M_CLR;
      e_v     = 0;
      e_ferr  = 0;
      e_lerr  = 0;
      e_instr = 32'h0;
      for (int i = 0; i < 64; i++) refm[i] = 32'h0;
   endtask

   task automatic drive(input bit fr, input logic [31:0] fa, input bit ls, input bit lv,
                        input logic [31:0] la, input logic [31:0] ld, input bit dn);
      ifc.fetch_req  = fr;
      ifc.fetch_addr = fa;
      ifc.ld_start   = ls;
      ifc.ld_valid   = lv;
      ifc.ld_addr    = la;
      ifc.ld_data    = ld;
      ifc.ld_done    = dn;
   endtask

   // one RUN/LOAD cycle: drive, check against model, advance model
   task automatic cyc(input bit fr, input logic [31:0] fa, input bit ls, input bit lv,
                      input logic [31:0] la, input logic [31:0] ld, input bit dn);
      bit fok, lok, exp_we, n_v, n_ferr;
      int fi, li;
      logic [31:0] n_instr;
      drive(fr, fa, ls, lv, la, ld, dn);
      fok = (fa % 4 == 0) && (fa < 256);
      lok = (la % 4 == 0) && (la < 256);
      fi  = fok ? int'(fa / 4) : 0;
      li  = lok ? int'(la / 4) : 0;
      @(negedge clk);
      chk("fetch_stall", 32'(ifc.fetch_stall), 32'(mode != M_RUN));
      chk("ld_ready", 32'(ifc.ld_ready), 32'(mode == M_LOAD));
      chk("busy", 32'(ifc.busy), 32'd0);
      chk("ld_err", 32'(ifc.ld_err), 32'(e_lerr));
      chk("fetch_valid", 32'(ifc.fetch_valid), 32'(e_v));
      chk("fetch_instr", ifc.fetch_instr, e_instr);
      if (e_v) chk("fetch_err", 32'(ifc.fetch_err), 32'(e_ferr));
      exp_we = (mode == M_LOAD) && lv && lok;
      chk("mem_we", 32'(ifc.mem_we), 32'(exp_we));
      if (exp_we) begin
         chk("ld_mem_addr", 32'(ifc.mem_addr), 32'(li));
         chk("ld_mem_wdata", ifc.mem_wdata, ld);
      end
      if (mode == M_RUN && fr && fok) chk("fetch_mem_addr", 32'(ifc.mem_addr), 32'(fi));
      n_v     = (mode == M_RUN) && fr;
      n_ferr  = n_v && !fok;
      n_instr = e_instr;
      if (n_v) n_instr = fok ? refm[fi] : 32'h0000_0013;
      if (mode == M_LOAD && lv) begin
         if (lok) refm[li] = ld;
         else     e_lerr = 1;
      end
      if (mode == M_RUN && ls) begin
         mode   = M_LOAD;
         e_lerr = 0;
      end else if (mode == M_LOAD && dn) begin
         mode = M_RUN;
      end
      @(posedge clk); #1;
      e_v     = n_v;
      e_ferr  = n_ferr;
      e_instr = n_instr;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic fetch(input logic [31:0] a);
      cyc(1, a, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d, input bit dn);
      cyc(0, 0, 0, 1, a, d, dn);
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++)
         cyc($urandom_range(0, 1), rand_addr(), $urandom_range(0, 19) == 0,
             $urandom_range(0, 1), rand_addr(), $urandom, $urandom_range(0, 9) == 0);
   endtask

   // reset asserted at the next edge; outputs must show reset values after it
   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_fetch_valid", 32'(ifc.fetch_valid), 32'd0);
      chk("rst_fetch_instr", ifc.fetch_instr, 32'h0);
      chk("rst_fetch_err", 32'(ifc.fetch_err), 32'd0);
      chk("rst_fetch_stall", 32'(ifc.fetch_stall), 32'd1);
      chk("rst_ld_ready", 32'(ifc.ld_ready), 32'd0);
      chk("rst_ld_err", 32'(ifc.ld_err), 32'd0);
      chk("rst_busy", 32'(ifc.busy), 32'd1);
      chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(ifc.mem_addr), 32'd0);
      chk("rst_mem_wdata", ifc.mem_wdata, 32'h0);
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // zero-fill after reset release: DEPTH writes at ascending addresses
   task automatic clear_phase();
      int wcnt = 0;
      bool_loop: for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!ifc.fetch_stall) break;
         chk("clr_busy", 32'(ifc.busy), 32'd1);
         if (ifc.mem_we) begin
            chk("clr_addr", 32'(ifc.mem_addr), 32'(wcnt));
            chk("clr_wdata", ifc.mem_wdata, 32'h0);
            wcnt++;
         end
         @(posedge clk); #1;
      end
      chk("clr_stall_released", 32'(ifc.fetch_stall), 32'd0);
      chk("clr_write_count", 32'(wcnt), 32'd64);
      chk("clr_busy_end", 32'(ifc.busy), 32'd0);
      @(posedge clk); #1;
      mode = M_RUN;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      clear_phase();

      // fetches from the cleared image, back to back
      idle();
      fetch(32'h04); fetch(32'h08); fetch(32'h0C);
      idle();

      // load session; last write coincides with ld_done
      cyc(0, 0, 1, 0, 0, 0, 0);
      load(32'h04, $urandom, 0);
      load(32'h08, $urandom, 0);
      load(32'h0C, $urandom, 0);
      load(32'h10, 32'h0020_8033, 1);
      fetch(32'h04); fetch(32'h08); fetch(32'h0C); fetch(32'h10);
      idle();

      // rejected fetch addresses
      fetch(32'h06); fetch(32'h100);
      idle();

      // fetch together with ld_start: response lands in LOAD
      cyc(1, 32'h10, 1, 0, 0, 0, 0);
      cyc(1, 32'h10, 0, 1, 32'h0102, 32'hdead_beef, 0);
      cyc(1, 32'h0C, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 32'h10, 0, 0, 0, 0, 1);
      idle();

      rand_cycles(400);

      // reset in the middle of a load session with ld_err set
      if (mode == M_RUN) cyc(0, 0, 1, 0, 0, 0, 0);
      load(32'h3, 32'h1, 0);
      load(32'h20, 32'h1234_5678, 0);
      drive(0, 0, 0, 1, 32'h24, 32'h0bad_f00d, 0);
      do_reset();
      clear_phase();
      fetch(32'h20); fetch(32'h10);
      idle();
      rand_cycles(150);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
